i2s_rx: RTL and testbench
=========================

Name: i2s_rx

Overview:
- I2S receiver for the codec ADC path. It deserialises the codec's sdata into parallel left/right samples.
- It runs on the same sclk and lrclk as the I2S transmitter and produces words in the same left_chan/right_chan format, so downstream DSP can loop ADC to DAC directly.
- A stereo pair is committed atomically, with a one-cycle valid strobe.

Parameters:
- BITSIZE, 16, sample width in bits; legal range 8..32.

Ports:
- sclk  input  1  bit clock; all logic on posedge sclk.
- rst  input  1  synchronous reset, active-high.
- lrclk  input  1  word select from codec/master; 0 = left slot, 1 = right slot.
- sdata  input  1  serial data from codec ADC, MSB first.
- left_chan  output  BITSIZE  last committed left sample.
- right_chan  output  BITSIZE  last committed right sample.
- sample_valid  output  1  one-cycle pulse when left_chan/right_chan update.
- frame_err  output  1  one-cycle pulse when a slot ends before BITSIZE bits are captured.

Behaviour:
- Reset (rst=1 at posedge):
  - left_chan=0, right_chan=0, sample_valid=0, frame_err=0.
  - Bit counter 0, shift register 0, left-hold-valid flag 0.
  - FSM to SYNC; lrclk_d <= lrclk, so no false edge is detected on reset exit.
- Edge detect: edge = (lrclk != lrclk_d); lrclk_d registered every cycle.
- The edge cycle is the delay slot of the new channel. Its sdata bit belongs to the previous slot.
- Bit positions:
  - bitpos is 0 on the edge cycle and increments per cycle, saturating at BITSIZE+1.
  - Capture occurs at bitpos 1..BITSIZE-1 of the current slot, MSB first.
  - The LSB is captured either at bitpos BITSIZE, or on the next edge cycle when the slot length is exactly BITSIZE.
  - Bits after the LSB are ignored; slots may be any length ≥ BITSIZE sclks.
- FSM:
  - SYNC: ignore data until a falling lrclk edge, then go to SHIFT (left slot).
  - SHIFT: capture bits. After BITSIZE bits, complete the word and go to PAD. Also complete on an edge cycle if BITSIZE-1 bits were captured, the edge bit being the LSB.
  - PAD: wait for an edge. On the edge, go to SHIFT for the opposite channel with bitpos=0.
  - Edge in SHIFT with fewer than BITSIZE-1 bits captured: discard the partial word, pulse frame_err the next cycle, clear the left-hold-valid flag, and go to SHIFT for the new channel.
- Word completion:
  - Left word: store in the hold register and set left-hold-valid.
  - Right word with left-hold-valid set: on the next posedge, left_chan <= hold, right_chan <= word, sample_valid=1 for exactly one cycle, and left-hold-valid is cleared.
  - Right word with left-hold-valid clear: discarded, no strobe.
- Latency: sample_valid is high in the cycle after the right LSB is sampled.
- Outputs hold their value between commits.
- Reset mid-frame: the partial word is lost and the FSM resynchronises on the next falling lrclk edge.

Optional Feature:
- Macro I2S_RX_ERRCNT_EN.
- Defined: adds output port err_count [7:0].
  - Saturating count of frame_err pulses; saturates at 255.
  - Reset to 0 by rst.
- Undefined: the port and the counter are absent; frame_err behaviour is unchanged.

Decomposition:
- Package i2s_pkg:
  - I2S_BITSIZE_DEFAULT=16.
  - Channel encoding constants CH_LEFT=0, CH_RIGHT=1.
  - FSM state enum {SYNC, SHIFT, PAD}.
- Sub-module i2s_lrclk_edge:
  - Registers lrclk and outputs the edge, rise and fall pulses.
  - Synchronous reset loads the current lrclk.
  - Reusable by the transmitter.

Test Plan:
- 64-sclk slots, left=16'hA5C3, right=16'h3C5A, BITSIZE=16 -> one sample_valid pulse per frame, exactly one cycle after the right LSB; left_chan=A5C3, right_chan=3C5A.
- Exact 16-sclk slots, left=16'h8001, right=16'h7FFE -> the LSB taken on the edge cycle is captured correctly; outputs 8001/7FFE, one strobe per 32 sclks.
- Left slot shortened to 10 sclks -> frame_err pulses once; no sample_valid for that frame; the next full frame commits normally.
- Assert rst for 2 cycles mid left slot with lrclk=1 at release -> all outputs 0; no strobe until a falling edge, then a full left+right frame.
- Reset release during a right slot -> the first right word is discarded and the first strobe comes from the following full frame.
- With I2S_RX_ERRCNT_EN, 300 short slots -> err_count=255 (saturated); rst returns it to 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S receive path.
// Also used by the I2S transmitter, so channel encoding stays consistent.
package i2s_pkg;

  localparam int I2S_BITSIZE_DEFAULT = 16;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    SYNC,
    SHIFT,
    PAD
  } i2s_state_e;

endpackage

// File: rtl/i2s_lrclk_edge.sv
// Word-select edge detector: registers lrclk and flags any toggle, rise or fall.
// Reset reloads the current lrclk, so the first cycle after reset sees no edge.
module i2s_lrclk_edge (
  input  logic sclk,
  input  logic rst,
  input  logic lrclk,
  output logic edge_pulse,
  output logic rise,
  output logic fall
);

  logic lrclk_d;

  always_ff @(posedge sclk) begin
    // NOTE: sequential state is written with <= only, so every read in the
    // same clock sees the value from before the edge.
    lrclk_d <= lrclk;
  end

  // Pulses are masked while in reset; the register reloads lrclk regardless.
  assign edge_pulse = !rst && (lrclk != lrclk_d);
  assign rise       = edge_pulse && lrclk;
  assign fall       = edge_pulse && !lrclk;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserialises sdata into left/right words and commits each stereo pair atomically.
// Optional I2S_RX_ERRCNT_EN adds a saturating 8-bit count of frame_err pulses on port err_count.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int BITSIZE = I2S_BITSIZE_DEFAULT
) (
  input  logic               sclk,
  input  logic               rst,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               sample_valid,
  output logic               frame_err
`ifdef I2S_RX_ERRCNT_EN
  ,
  output logic [7:0]         err_count
`endif
);

  localparam int CNT_W = $clog2(BITSIZE + 1);
  localparam logic [CNT_W-1:0] LSB_CNT = CNT_W'(BITSIZE - 1);

  logic               edge_pulse;
  logic               lr_rise;
  logic               lr_fall;
  i2s_state_e         state;
  logic               chan;
  logic [CNT_W-1:0]   bit_cnt;
  logic [BITSIZE-2:0] shreg;
  logic [BITSIZE-1:0] hold;
  logic               hold_valid;
  logic [BITSIZE-1:0] word;
  logic               word_done;

  i2s_lrclk_edge u_lrclk_edge (
    .sclk       (sclk),
    .rst        (rst),
    .lrclk      (lrclk),
    .edge_pulse (edge_pulse),
    .rise       (lr_rise),
    .fall       (lr_fall)
  );

  // The current sdata bit is the LSB whenever BITSIZE-1 bits are already held,
  // whether it arrives mid-slot or in the delay slot of the next channel.
  assign word      = {shreg, sdata};
  assign word_done = (state == SHIFT) && (bit_cnt == LSB_CNT);

  always_ff @(posedge sclk) begin
    if (rst) begin
      state        <= SYNC;
      chan         <= CH_LEFT;
      bit_cnt      <= '0;
      shreg        <= '0;
      hold         <= '0;
      hold_valid   <= 1'b0;
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
`ifdef I2S_RX_ERRCNT_EN
      err_count    <= '0;
`endif
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;

      if (word_done) begin
        if (chan == CH_LEFT) begin
          hold       <= word;
          hold_valid <= 1'b1;
        end else if (hold_valid) begin
          left_chan    <= hold;
          right_chan   <= word;
          sample_valid <= 1'b1;
          hold_valid   <= 1'b0;
        end
      end

      case (state)
        SYNC: begin
          if (lr_fall) begin
            state   <= SHIFT;
            chan    <= CH_LEFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (edge_pulse) begin
            // A slot that ends early poisons the pair: drop any held left word.
            if (!word_done) begin
              frame_err  <= 1'b1;
              hold_valid <= 1'b0;
`ifdef I2S_RX_ERRCNT_EN
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
            end
            chan    <= lr_rise ? CH_RIGHT : CH_LEFT;
            bit_cnt <= '0;
          end else begin
            shreg   <= word[BITSIZE-2:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (word_done) state <= PAD;
          end
        end
        PAD: begin
          if (edge_pulse) begin
            state   <= SHIFT;
            chan    <= lr_rise ? CH_RIGHT : CH_LEFT;
            bit_cnt <= '0;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: random slot streams checked against a slot-level model.
// Define I2S_RX_ERRCNT_EN for both bench and RTL to exercise err_count.
module tb_i2s_rx;

  localparam int BITS = 16;

  logic            sclk;
  logic            rst;
  logic            lrclk;
  logic            sdata;
  logic [BITS-1:0] left_chan;
  logic [BITS-1:0] right_chan;
  logic            sample_valid;
  logic            frame_err;
`ifdef I2S_RX_ERRCNT_EN
  logic [7:0]      err_count;
`endif

  int checks = 0;
  int errors = 0;

  // Slot list for the next stream: slot 0 is always left, then alternating.
  int              slot_len[$];
  logic [BITS-1:0] slot_dat[$];

  i2s_rx #(.BITSIZE(BITS)) dut (
    .sclk         (sclk),
    .rst          (rst),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .left_chan    (left_chan),
    .right_chan   (right_chan),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
`ifdef I2S_RX_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset(input int cycles, input logic lr_level);
    @(negedge sclk);
    rst   = 1'b1;
    lrclk = lr_level;
    sdata = 1'($urandom_range(0, 1));
    repeat (cycles) @(posedge sclk);
    @(negedge sclk);
    rst = 1'b0;
  endtask

  task automatic add_slot(input int len, input logic [BITS-1:0] dat);
    slot_len.push_back(len);
    slot_dat.push_back(dat);
  endtask

  task automatic clear_slots();
    slot_len.delete();
    slot_dat.delete();
  endtask

  // Builds the bit stream from the slot list, predicts every cycle's outputs
  // from the slot rules, drives it and compares cycle by cycle.
  task automatic run_stream(input string name, input int lead, input int stop_at,
                            output int obs_strobes, output int obs_errs);
    bit              lr[$];
    bit              sd[$];
    int              start[$];
    bit              ev[];
    bit              ee[];
    logic [BITS-1:0] cl[];
    logic [BITS-1:0] cr[];
    logic [BITS-1:0] cur_l;
    logic [BITS-1:0] cur_r;
    logic [BITS-1:0] hold;
    bit              hv;
    int              n;
    int              limit;
    logic [2*BITS+1:0] got;
    logic [2*BITS+1:0] exp_v;

    for (int i = 0; i < lead; i++) begin
      lr.push_back(1'b1);
      sd.push_back(1'($urandom_range(0, 1)));
    end
    for (int j = 0; j < slot_len.size(); j++) begin
      start.push_back(lr.size());
      for (int k = 0; k < slot_len[j]; k++) begin
        lr.push_back(1'(j % 2));
        sd.push_back(1'($urandom_range(0, 1)));
      end
    end
    n = lr.size();
    // Data bit i (MSB first) sits one cycle after the slot's edge plus i.
    for (int j = 0; j < slot_len.size(); j++)
      for (int i = 0; i < BITS && i < slot_len[j]; i++)
        if (start[j] + 1 + i < n) sd[start[j] + 1 + i] = slot_dat[j][BITS-1-i];

    ev = new[n];
    ee = new[n];
    cl = new[n];
    cr = new[n];
    for (int c = 0; c < n; c++) begin
      ev[c] = 1'b0;
      ee[c] = 1'b0;
      cl[c] = '0;
      cr[c] = '0;
    end
    hv   = 1'b0;
    hold = '0;
    for (int j = 0; j < slot_len.size(); j++) begin
      if (slot_len[j] >= BITS) begin
        if (j % 2 == 0) begin
          hold = slot_dat[j];
          hv   = 1'b1;
        end else if (hv) begin
          if (start[j] + BITS < n) begin
            ev[start[j] + BITS] = 1'b1;
            cl[start[j] + BITS] = hold;
            cr[start[j] + BITS] = slot_dat[j];
          end
          hv = 1'b0;
        end
      end else begin
        if (j + 1 < slot_len.size()) ee[start[j] + slot_len[j]] = 1'b1;
        hv = 1'b0;
      end
    end

    limit       = (stop_at > 0 && stop_at < n) ? stop_at : n;
    cur_l       = '0;
    cur_r       = '0;
    obs_strobes = 0;
    obs_errs    = 0;
    lrclk       = lr[0];
    sdata       = sd[0];
    for (int c = 0; c < limit; c++) begin
      @(posedge sclk);
      @(negedge sclk);
      if (ev[c]) begin
        cur_l = cl[c];
        cur_r = cr[c];
      end
      got   = {sample_valid, frame_err, left_chan, right_chan};
      exp_v = {ev[c], ee[c], cur_l, cur_r};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: got valid=%b err=%b left=%h right=%h, expected valid=%b err=%b left=%h right=%h",
                 name, c, sample_valid, frame_err, left_chan, right_chan, ev[c], ee[c], cur_l, cur_r);
      end
      if (sample_valid === 1'b1) obs_strobes++;
      if (frame_err === 1'b1) obs_errs++;
      if (c + 1 < limit) begin
        lrclk = lr[c + 1];
        sdata = sd[c + 1];
      end
    end
  endtask

  task automatic test_reset();
    apply_reset(3, 1'b1);
    checks++;
    if ({sample_valid, frame_err, left_chan, right_chan} !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b err=%b left=%h right=%h, expected all zero",
               sample_valid, frame_err, left_chan, right_chan);
    end
  endtask

  task automatic test_long_slots();
    int s, e;
    apply_reset(2, 1'b1);
    clear_slots();
    for (int f = 0; f < 3; f++) begin
      add_slot(64, 16'hA5C3);
      add_slot(64, 16'h3C5A);
    end
    run_stream("long_slots", 5, 0, s, e);
    checks++;
    if (s !== 3 || e !== 0) begin
      errors++;
      $display("FAIL long_slots_count: got strobes=%0d errs=%0d, expected strobes=3 errs=0", s, e);
    end
    checks++;
    if (left_chan !== 16'hA5C3 || right_chan !== 16'h3C5A) begin
      errors++;
      $display("FAIL long_slots_value: got left=%h right=%h, expected left=a5c3 right=3c5a", left_chan, right_chan);
    end
  endtask

  task automatic test_exact_slots();
    int s, e;
    apply_reset(2, 1'b1);
    clear_slots();
    for (int f = 0; f < 4; f++) begin
      add_slot(BITS, 16'h8001);
      add_slot(BITS, 16'h7FFE);
    end
    add_slot(BITS + 4, 16'h1234);
    run_stream("exact_slots", 2, 0, s, e);
    checks++;
    if (s !== 4 || left_chan !== 16'h8001 || right_chan !== 16'h7FFE) begin
      errors++;
      $display("FAIL exact_slots: got strobes=%0d left=%h right=%h, expected strobes=4 left=8001 right=7ffe",
               s, left_chan, right_chan);
    end
  endtask

  task automatic test_short_slot();
    int s, e;
    apply_reset(2, 1'b1);
    clear_slots();
    add_slot(64, 16'h1111);
    add_slot(64, 16'h2222);
    add_slot(10, 16'h3333);
    add_slot(64, 16'h4444);
    add_slot(64, 16'h5555);
    add_slot(64, 16'h6666);
    run_stream("short_slot", 3, 0, s, e);
    checks++;
    if (s !== 2 || e !== 1 || left_chan !== 16'h5555 || right_chan !== 16'h6666) begin
      errors++;
      $display("FAIL short_slot: got strobes=%0d errs=%0d left=%h right=%h, expected strobes=2 errs=1 left=5555 right=6666",
               s, e, left_chan, right_chan);
    end
  endtask

  task automatic test_reset_mid_frame();
    int s, e;
    apply_reset(2, 1'b1);
    clear_slots();
    add_slot(40, 16'hBEEF);
    add_slot(40, 16'hCAFE);
    add_slot(40, 16'h0F0F);
    add_slot(40, 16'hF0F0);
    run_stream("pre_reset", 4, 4 + 80 + 20, s, e);
    apply_reset(2, 1'b1);
    checks++;
    if ({sample_valid, frame_err, left_chan, right_chan} !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: got valid=%b err=%b left=%h right=%h, expected all zero",
               sample_valid, frame_err, left_chan, right_chan);
    end
    // Long lead at lrclk=1 stands in for a right slot already in progress at reset release.
    clear_slots();
    add_slot(32, 16'h1357);
    add_slot(32, 16'h2468);
    run_stream("post_reset", 30, 0, s, e);
    checks++;
    if (s !== 1 || left_chan !== 16'h1357 || right_chan !== 16'h2468) begin
      errors++;
      $display("FAIL post_reset_frame: got strobes=%0d left=%h right=%h, expected strobes=1 left=1357 right=2468",
               s, left_chan, right_chan);
    end
  endtask

  task automatic test_random_frames();
    int s, e, len;
    for (int r = 0; r < 6; r++) begin
      apply_reset(2, 1'b1);
      clear_slots();
      for (int j = 0; j < 12; j++) begin
        case ($urandom_range(0, 3))
          0:       len = $urandom_range(2, BITS - 1);
          1:       len = $urandom_range(BITS - 1, BITS + 1);
          default: len = $urandom_range(BITS + 2, 48);
        endcase
        add_slot(len, BITS'($urandom));
      end
      add_slot($urandom_range(BITS + 1, 40), BITS'($urandom));
      run_stream("random_frames", $urandom_range(1, 20), 0, s, e);
    end
  endtask

`ifdef I2S_RX_ERRCNT_EN
  task automatic test_err_count();
    int s, e;
    apply_reset(2, 1'b1);
    clear_slots();
    for (int j = 0; j < 300; j++) add_slot($urandom_range(3, 6), BITS'($urandom));
    add_slot(BITS + 4, BITS'($urandom));
    run_stream("err_count_stream", 2, 0, s, e);
    checks++;
    if (err_count !== 8'd255 || e !== 300) begin
      errors++;
      $display("FAIL err_count_sat: got count=%0d pulses=%0d, expected count=255 pulses=300", err_count, e);
    end
    apply_reset(2, 1'b1);
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("FAIL err_count_reset: got %0d, expected 0", err_count);
    end
  endtask
`endif

  initial begin
    rst   = 1'b1;
    lrclk = 1'b1;
    sdata = 1'b0;
    test_reset();
    test_long_slots();
    test_exact_slots();
    test_short_slot();
    test_reset_mid_frame();
    test_random_frames();
`ifdef I2S_RX_ERRCNT_EN
    test_err_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
